pwm_deadtime_gen: RTL and testbench
===================================

PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 SHALL have parameter N, default 8, meaning counter and duty width; the PWM period is 2^N clk cycles.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning the number of independent complementary PWM channels.
REQ-003 SHALL have parameter DT_W, default 4, meaning the dead-time field width in clk cycles.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ena  input  1  global enable; 0 forces all outputs low and clears the fault latch.
REQ-007 SHALL have port duty  input  CHANNELS*N  packed per-channel duty requests; channel i occupies bits [i*N +: N].
REQ-008 SHALL have port dead_time  input  DT_W  dead-time request in clk cycles, common to all channels.
REQ-009 SHALL have port load  input  1  one-cycle strobe that captures duty and dead_time into shadow registers.
REQ-010 SHALL have port fault_n  input  1  synchronous active-low fault input.
REQ-011 SHALL have port hi  output  CHANNELS  high-side gate commands.
REQ-012 SHALL have port lo  output  CHANNELS  low-side gate commands.
REQ-013 SHALL have port period_start  output  1  one-cycle pulse when the counter wraps to 0.
REQ-014 SHALL have port fault  output  1  latched fault status.

Function
REQ-015 SHALL run a free counter cnt from 0 to 2^N-1 while ena=1 and no fault is latched, then wrap to 0; period_start=1 in the cycle cnt=0 follows a wrap.
REQ-016 SHALL copy the shadow duty and dead_time into the active registers only on wrap, and on the first cycle after ena rises; a load mid-period has no effect until the next period.
REQ-017 SHALL capture the latest values when load coincides with a wrap; those values become active one period later.
REQ-018 SHALL compute raw_i = (cnt < duty_i), except that duty_i = 2^N-1 forces raw_i = 1 (100 %) and duty_i = 0 forces raw_i = 0.
REQ-019 SHALL give each channel an FSM with states IDLE, LOW_ON, DEAD and HIGH_ON.
- IDLE: hi=lo=0.
- LOW_ON: lo=1.
- HIGH_ON: hi=1.
- DEAD: hi=lo=0.
REQ-020 SHALL leave IDLE for DEAD with timer=1 when enabled.
REQ-021 SHALL move LOW_ON with raw=1, or HIGH_ON with raw=0, to DEAD with timer=1 on the next cycle; if active dead_time=0, the move goes directly to the opposite ON state.
REQ-022 SHALL, in DEAD, increment timer each cycle; when timer >= dead_time the channel moves to HIGH_ON if raw=1, else LOW_ON. A raw pulse shorter than dead_time is therefore swallowed.
REQ-023 SHALL never assert hi_i and lo_i in the same cycle under any input sequence.
REQ-024 SHALL register outputs; an output turn-off occurs exactly 1 cycle after the raw edge, and the opposite turn-on occurs dead_time+1 cycles after it.
REQ-025 SHALL, on fault_n=0 while ena=1, set fault on the next edge and force all channels to IDLE in the same edge; fault stays 1 until ena=0.
REQ-026 SHALL, on ena=0, hold cnt at 0, put all channels in IDLE and clear fault on the next edge; shadow registers are retained.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-period or mid-dead-time, immediately clear the following:
- hi, lo, period_start and fault to 0;
- cnt to 0;
- all channel FSMs to IDLE with timer 0;
- shadow and active duty and dead_time to 0.
REQ-028 SHALL resume counting from cnt=0 on the first edge after rst_n rises with ena=1.

Structure
REQ-029 SHALL place the channel state enum (IDLE, LOW_ON, DEAD, HIGH_ON) and the default parameter constants in shared package pwm_pkg.
REQ-030 SHALL instantiate one sub-module pwm_deadtime_ch per channel via generate, holding the FSM and timer; the counter, shadow logic and fault latch live in the top level.

Verification
REQ-031 SHALL cover: rst_n=0 pulsed mid-period with duty=128 -> hi=lo=0, cnt=0 and fault=0 immediately; the counter restarts at 0 after release.
REQ-032 SHALL cover: N=8, duty0=128, dead_time=4 -> per 256-cycle period hi0 high 124 cycles and lo0 high 124 cycles, with two 4-cycle both-low gaps and no overlap.
REQ-033 SHALL cover: load with duty0=192 at cnt=50 -> the current period keeps 128; from the next period_start hi0 is high 188 cycles.
REQ-034 SHALL cover: duty0=0 -> lo0 is continuously high after the initial dead-time; duty1=255 -> hi1 is continuously high; period_start still pulses every 256 cycles.
REQ-035 SHALL cover: duty0=2, dead_time=4 -> hi0 is never asserted, lo0 drops for exactly 4 cycles per period, and dead_time=0 gives complementary switching with 1-cycle latency.
REQ-036 SHALL cover: fault_n=0 for 1 cycle at cnt=100 -> next edge all hi/lo=0 and fault=1, held until ena toggles 1-0-1, after which the counter restarts at cnt=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the complementary PWM generator with dead-time insertion.
package pwm_pkg;

    localparam int unsigned DefN        = 8;
    localparam int unsigned DefChannels = 2;
    localparam int unsigned DefDtW      = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLowOn  = 2'd1,
        StDead   = 2'd2,
        StHighOn = 2'd3
    } ch_state_e;

endpackage

// File: rtl/pwm_deadtime_ch.sv
// One complementary PWM channel: raw compare, dead-time FSM and registered gate outputs.
module pwm_deadtime_ch
    import pwm_pkg::*;
#(
    parameter int unsigned N    = DefN,
    parameter int unsigned DT_W = DefDtW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic [N-1:0]    i_cnt,
    input  logic [N-1:0]    i_duty,
    input  logic [DT_W-1:0] i_dead_time,
    output logic            o_hi,
    output logic            o_lo
);

    localparam logic [N-1:0]    DutyFull = {N{1'b1}};
    localparam logic [DT_W-1:0] TimerOne = DT_W'(1);

    ch_state_e       r_state;
    ch_state_e       w_state_d;
    logic [DT_W-1:0] r_timer;
    logic [DT_W-1:0] w_timer_d;
    logic            w_raw;
    logic            r_hi;
    logic            r_lo;

    // All-ones duty means 100 % so the top count value is covered too.
    always_comb begin
        w_raw = 1'b0;
        if (i_duty == DutyFull) begin
            w_raw = 1'b1;
        end else if (i_duty != '0) begin
            w_raw = (i_cnt < i_duty);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        if (!i_en) begin
            w_state_d = StIdle;
            w_timer_d = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_d = StDead;
                    w_timer_d = TimerOne;
                end
                StLowOn: begin
                    if (w_raw) begin
                        if (i_dead_time == '0) begin
                            w_state_d = StHighOn;
                        end else begin
                            w_state_d = StDead;
                            w_timer_d = TimerOne;
                        end
                    end
                end
                StHighOn: begin
                    if (!w_raw) begin
                        if (i_dead_time == '0) begin
                            w_state_d = StLowOn;
                        end else begin
                            w_state_d = StDead;
                            w_timer_d = TimerOne;
                        end
                    end
                end
                StDead: begin
                    // The exit side is chosen from raw at expiry, so short raw pulses vanish.
                    if (r_timer >= i_dead_time) begin
                        w_state_d = w_raw ? StHighOn : StLowOn;
                        w_timer_d = '0;
                    end else begin
                        w_timer_d = r_timer + TimerOne;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_hi    <= (w_state_d == StHighOn);
            r_lo    <= (w_state_d == StLowOn);
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Multi-channel complementary PWM generator: shared counter, shadowed settings and fault latch.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int unsigned N        = DefN,
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned DT_W     = DefDtW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [CHANNELS*N-1:0] duty,
    input  logic [DT_W-1:0]       dead_time,
    input  logic                  load,
    input  logic                  fault_n,
    output logic [CHANNELS-1:0]   hi,
    output logic [CHANNELS-1:0]   lo,
    output logic                  period_start,
    output logic                  fault
);

    localparam logic [N-1:0] CntMax = {N{1'b1}};
    localparam logic [N-1:0] CntOne = N'(1);

    logic [N-1:0]          r_cnt;
    logic                  r_ena_q;
    logic                  r_fault;
    logic                  r_period_start;
    logic [CHANNELS*N-1:0] r_shadow_duty;
    logic [CHANNELS*N-1:0] r_act_duty;
    logic [DT_W-1:0]       r_shadow_dt;
    logic [DT_W-1:0]       r_act_dt;

    logic                  w_halt;
    logic                  w_start;
    logic                  w_wrap;
    logic                  w_reload;
    logic                  w_ch_en;
    logic [CHANNELS-1:0]   w_hi;
    logic [CHANNELS-1:0]   w_lo;

    // A fresh enable restarts the period at cnt=0 with the shadow values made active.
    assign w_halt   = !ena || r_fault || !fault_n;
    assign w_start  = ena && !r_ena_q;
    assign w_wrap   = !w_halt && r_ena_q && (r_cnt == CntMax);
    assign w_reload = w_start || w_wrap;
    assign w_ch_en  = !w_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_ena_q        <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_ena_q        <= ena;
            r_period_start <= w_wrap;
            if (w_halt || w_start) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (!ena) begin
            r_fault <= 1'b0;
        end else if (!fault_n) begin
            r_fault <= 1'b1;
        end
    end

    // Active settings sample the shadow before this edge's load lands in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_duty <= '0;
            r_shadow_dt   <= '0;
            r_act_duty    <= '0;
            r_act_dt      <= '0;
        end else begin
            if (load) begin
                r_shadow_duty <= duty;
                r_shadow_dt   <= dead_time;
            end
            if (w_reload) begin
                r_act_duty <= r_shadow_duty;
                r_act_dt   <= r_shadow_dt;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_deadtime_ch #(
            .N    (N),
            .DT_W (DT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_en        (w_ch_en),
            .i_cnt       (r_cnt),
            .i_duty      (r_act_duty[g*N +: N]),
            .i_dead_time (r_act_dt),
            .o_hi        (w_hi[g]),
            .o_lo        (w_lo[g])
        );
    end

    assign hi           = w_hi;
    assign lo           = w_lo;
    assign period_start = r_period_start;
    assign fault        = r_fault;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: per-period duty/dead-time measurements, fault and reset.
module tb_pwm_deadtime_gen;

    localparam int unsigned N        = 8;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DT_W     = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  ena;
    logic [CHANNELS*N-1:0] duty;
    logic [DT_W-1:0]       dead_time;
    logic                  load;
    logic                  fault_n;
    logic [CHANNELS-1:0]   hi;
    logic [CHANNELS-1:0]   lo;
    logic                  period_start;
    logic                  fault;

    int n_checks = 0;
    int n_errors = 0;
    int c_hi0, c_lo0, c_hi1, c_lo1, c_ovl, c_ps;
    logic [255:0] tr_hi0, tr_lo0;

    pwm_deadtime_gen #(
        .N        (N),
        .CHANNELS (CHANNELS),
        .DT_W     (DT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .duty         (duty),
        .dead_time    (dead_time),
        .load         (load),
        .fault_n      (fault_n),
        .hi           (hi),
        .lo           (lo),
        .period_start (period_start),
        .fault        (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts on a period_start sample, ends on the next one; optional mid-period load.
    task automatic measure(input int load_at, input logic [N-1:0] ld_duty0,
                           input logic [DT_W-1:0] ld_dt);
        c_hi0 = 0; c_lo0 = 0; c_hi1 = 0; c_lo1 = 0; c_ovl = 0; c_ps = 0;
        for (int i = 0; i < 256; i++) begin
            tr_hi0[i] = hi[0];
            tr_lo0[i] = lo[0];
            c_hi0 += int'(hi[0]);
            c_lo0 += int'(lo[0]);
            c_hi1 += int'(hi[1]);
            c_lo1 += int'(lo[1]);
            if ((hi & lo) != '0) c_ovl++;
            c_ps += int'(period_start);
            load = (i == load_at);
            if (i == load_at) begin
                duty[N-1:0] = ld_duty0;
                dead_time   = ld_dt;
            end
            tick();
        end
        load = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        int k;
        k = 0;
        while (period_start !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check(tag, 32'(k < 300), 32'd1);
    endtask

    initial begin
        int k;
        rst_n = 1'b1; ena = 1'b0; duty = '0; dead_time = '0; load = 1'b0; fault_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("reset_hi", 32'(hi), 32'd0);
        check("reset_lo", 32'(lo), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        tick();

        duty = {8'd255, 8'd128}; dead_time = 4'd4; load = 1'b1;
        tick();
        load = 1'b0; ena = 1'b1;
        tick();
        check("enable_dead_hi", 32'(hi), 32'd0);
        check("enable_dead_lo", 32'(lo), 32'd0);
        wait_ps("first_ps");

        // duty0=128, dt=4: 124/124 split with two 4-cycle gaps.
        measure(-1, 8'd0, 4'd0);
        check("d128_hi0", 32'(c_hi0), 32'd124);
        check("d128_lo0", 32'(c_lo0), 32'd124);
        check("d128_ovl", 32'(c_ovl), 32'd0);
        check("d255_hi1", 32'(c_hi1), 32'd256);
        check("d255_lo1", 32'(c_lo1), 32'd0);
        check("d128_ps", 32'(c_ps), 32'd1);

        // Mid-period load of 192 must not disturb the running period.
        measure(50, 8'd192, 4'd4);
        check("midload_hi0", 32'(c_hi0), 32'd124);
        check("midload_lo0", 32'(c_lo0), 32'd124);
        measure(-1, 8'd0, 4'd0);
        check("d192_hi0", 32'(c_hi0), 32'd188);
        check("d192_lo0", 32'(c_lo0), 32'd60);
        check("d192_ovl", 32'(c_ovl), 32'd0);
        check("d192_hi_c4", 32'(tr_hi0[4]), 32'd0);
        check("d192_hi_c5", 32'(tr_hi0[5]), 32'd1);
        check("d192_hi_c192", 32'(tr_hi0[192]), 32'd1);
        check("d192_hi_c193", 32'(tr_hi0[193]), 32'd0);

        measure(10, 8'd2, 4'd4);
        check("preload2_hi0", 32'(c_hi0), 32'd188);
        // duty0=2 is shorter than the dead time and must be swallowed.
        measure(20, 8'd0, 4'd4);
        check("d2_hi0", 32'(c_hi0), 32'd0);
        check("d2_lo0", 32'(c_lo0), 32'd252);
        check("d2_lo_c0", 32'(tr_lo0[0]), 32'd1);
        check("d2_lo_c1", 32'(tr_lo0[1]), 32'd0);
        check("d2_lo_c4", 32'(tr_lo0[4]), 32'd0);
        check("d2_lo_c5", 32'(tr_lo0[5]), 32'd1);

        measure(30, 8'd128, 4'd0);
        check("d0_lo0", 32'(c_lo0), 32'd256);
        check("d0_hi0", 32'(c_hi0), 32'd0);
        check("d0_hi1", 32'(c_hi1), 32'd256);
        check("d0_ps", 32'(c_ps), 32'd1);

        // Zero dead time: complementary switching one cycle after the raw edge.
        measure(-1, 8'd0, 4'd0);
        check("dt0_hi0", 32'(c_hi0), 32'd128);
        check("dt0_lo0", 32'(c_lo0), 32'd128);
        check("dt0_ovl", 32'(c_ovl), 32'd0);
        check("dt0_hi_c0", 32'(tr_hi0[0]), 32'd0);
        check("dt0_hi_c1", 32'(tr_hi0[1]), 32'd1);
        check("dt0_lo_c1", 32'(tr_lo0[1]), 32'd0);
        check("dt0_hi_c129", 32'(tr_hi0[129]), 32'd0);
        check("dt0_lo_c129", 32'(tr_lo0[129]), 32'd1);

        // Fault pulse at cnt=100.
        repeat (100) tick();
        check("prefault_hi0", 32'(hi[0]), 32'd1);
        fault_n = 1'b0;
        tick();
        fault_n = 1'b1;
        check("fault_hi", 32'(hi), 32'd0);
        check("fault_lo", 32'(lo), 32'd0);
        check("fault_set", 32'(fault), 32'd1);
        k = 0;
        repeat (300) begin
            if (period_start !== 1'b0 || hi !== '0 || lo !== '0) k++;
            tick();
        end
        check("fault_quiet", 32'(k), 32'd0);
        check("fault_held", 32'(fault), 32'd1);
        ena = 1'b0;
        tick();
        check("fault_clear", 32'(fault), 32'd0);
        ena = 1'b1;
        tick();
        check("restart_hi", 32'(hi), 32'd0);
        check("restart_lo", 32'(lo), 32'd0);
        k = 0;
        repeat (255) begin
            tick();
            k += int'(period_start);
        end
        check("restart_no_early_ps", 32'(k), 32'd0);
        tick();
        check("restart_ps_256", 32'(period_start), 32'd1);

        // Asynchronous reset mid-period.
        repeat (60) tick();
        check("prereset_hi0", 32'(hi[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_hi", 32'(hi), 32'd0);
        check("midreset_lo", 32'(lo), 32'd0);
        check("midreset_ps", 32'(period_start), 32'd0);
        check("midreset_fault", 32'(fault), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("postreset_dead", 32'(hi | lo), 32'd0);
        tick();
        check("postreset_lo_shadow0", 32'(lo), 32'd3);
        check("postreset_hi", 32'(hi), 32'd0);
        k = 0;
        repeat (254) begin
            tick();
            k += int'(period_start);
        end
        check("postreset_no_early_ps", 32'(k), 32'd0);
        tick();
        check("postreset_ps_256", 32'(period_start), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
